// File: rtl/muldiv_unit_if.sv
// Issue/writeback bundle between the execute stage and the RV32M multiply/divide unit.
// The master issues an operation; the slave (muldiv_unit) returns busy and the writeback.
interface muldiv_unit_if #(
  parameter int DW = 32
);
  logic          i_valid;
  logic [2:0]    i_op;
  logic [DW-1:0] i_rs1;
  logic [DW-1:0] i_rs2;
  logic          o_busy;
  logic          o_rd_write;
  logic [DW-1:0] o_rd;

  modport master (
    output i_valid, i_op, i_rs1, i_rs2,
    input  o_busy, o_rd_write, o_rd
  );

  modport slave (
    input  i_valid, i_op, i_rs1, i_rs2,
    output o_busy, o_rd_write, o_rd
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, BPC bits per cycle.
// DW must be even and >= 8; BPC is 1, 2 or 4 and divides DW.
module muldiv_unit #(
  parameter int DW  = 32,
  parameter int BPC = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clk_en,
  input  logic          i_stall,
  muldiv_unit_if.slave  bus
);
  localparam int            CW       = $clog2(DW / BPC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DW / BPC);

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  op_t           r_op;
  logic          r_neg;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_hi, r_lo, r_opb, r_result;

  op_t           w_op;
  logic          w_is_div, w_a_neg, w_b_neg, w_neg;
  logic          w_div_zero, w_ovf, w_special;
  logic [DW-1:0] w_a_abs, w_b_abs, w_special_res;

  // Issue decode: operand magnitudes, result sign and the no-iteration divide cases.
  always_comb begin
    w_op       = op_t'(bus.i_op);
    w_is_div   = bus.i_op[2];
    w_a_neg    = (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.i_rs1[DW-1];
    w_b_neg    = (w_op inside {OP_MULH, OP_DIV, OP_REM}) && bus.i_rs2[DW-1];
    w_a_abs    = w_a_neg ? -bus.i_rs1 : bus.i_rs1;
    w_b_abs    = w_b_neg ? -bus.i_rs2 : bus.i_rs2;
    w_neg      = (w_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = w_is_div && (bus.i_rs2 == '0);
    w_ovf      = (w_op inside {OP_DIV, OP_REM}) && (bus.i_rs1 == {1'b1, {(DW-1){1'b0}}})
                 && (bus.i_rs2 == '1);
    w_special  = w_div_zero || w_ovf;
    if (w_div_zero) w_special_res = bus.i_op[1] ? bus.i_rs1 : '1;
    else            w_special_res = bus.i_op[1] ? '0 : bus.i_rs1;
  end

  logic [DW-1:0]   w_hi_step, w_lo_step;
  logic [DW:0]     w_rem_sh, w_diff, w_sum;
  logic [2*DW-1:0] w_prod, w_prod_c;
  logic [DW-1:0]   w_quo_c, w_rem_c, w_final;

  // One iteration = BPC single-bit steps. Multiply: hi accumulates the partial product
  // while the multiplier shifts out of lo. Divide: hi is the remainder, lo the quotient.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_hi_step = r_hi;
    w_lo_step = r_lo;
    w_rem_sh  = '0;
    w_diff    = '0;
    w_sum     = '0;
    for (int i = 0; i < BPC; i++) begin
      if (r_op[2]) begin
        w_rem_sh  = {w_hi_step, w_lo_step[DW-1]};
        w_diff    = w_rem_sh - {1'b0, r_opb};
        w_lo_step = {w_lo_step[DW-2:0], ~w_diff[DW]};
        w_hi_step = w_diff[DW] ? w_rem_sh[DW-1:0] : w_diff[DW-1:0];
      end else begin
        w_sum     = {1'b0, w_hi_step} + (w_lo_step[0] ? {1'b0, r_opb} : '0);
        w_lo_step = {w_sum[0], w_lo_step[DW-1:1]};
        w_hi_step = w_sum[DW:1];
      end
    end
    w_prod   = {w_hi_step, w_lo_step};
    w_prod_c = r_neg ? -w_prod : w_prod;
    w_quo_c  = r_neg ? -w_lo_step : w_lo_step;
    w_rem_c  = r_neg ? -w_hi_step : w_hi_step;
    unique case (r_op)
      OP_MUL:                        w_final = w_prod_c[DW-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_final = w_prod_c[2*DW-1:DW];
      OP_DIV, OP_DIVU:               w_final = w_quo_c;
      default:                       w_final = w_rem_c;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.i_valid) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE:  if (!i_stall) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst)         r_state <= S_IDLE;
    else if (i_clk_en) r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else if (i_clk_en) begin
      unique case (r_state)
        S_IDLE: if (bus.i_valid) begin
          r_op  <= w_op;
          r_neg <= w_neg;
          r_cnt <= CNT_LOAD;
          r_hi  <= '0;
          r_lo  <= w_is_div ? w_a_abs : w_b_abs;
          r_opb <= w_is_div ? w_b_abs : w_a_abs;
          if (w_special) r_result <= w_special_res;
        end
        S_CALC: begin
          r_hi  <= w_hi_step;
          r_lo  <= w_lo_step;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy     = (r_state != S_IDLE);
  assign bus.o_rd_write = (r_state == S_DONE);
  assign bus.o_rd       = (r_state == S_DONE) ? r_result : '0;
endmodule
